// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, FSM encoding and event/modifier types.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POP    = 2'd1,
    ST_DECODE = 2'd2
  } state_t;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E1     = 8'hE1;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;

  // Keyboard status / error bytes that never form a key event
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;

  // Bytes following E1 in the Pause make sequence
  localparam logic [2:0] SKIP_LEN  = 3'd7;

  typedef struct packed {
    logic lshift;
    logic rshift;
    logic lctrl;
    logic rctrl;
    logic lalt;
    logic ralt;
  } mod_bits_t;

  function automatic logic is_discard(input logic [7:0] b);
    return (b == SC_ERR0) || (b == SC_ERR1) || (b == SC_BAT_OK) ||
           (b == SC_ACK)  || (b == SC_ECHO) || (b == SC_RESEND);
  endfunction

endpackage

// File: rtl/ps2_mod_tracker.sv
// Tracks the six held modifier keys from decoded events; updates on the strobe edge.
// Latency: one cycle from upd to bits/mods. No backpressure (strobe-driven).
module ps2_mod_tracker
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       upd,
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       brk,
  output mod_bits_t  bits,
  output logic [2:0] mods
);

  // Extended 12/59 are the "fake shift" codes and must not touch the shift bits
  always_ff @(posedge clk) begin
    if (rst) begin
      bits <= '0;
    end else if (upd) begin
      case (code)
        SC_LSHIFT: if (!ext) bits.lshift <= !brk;
        SC_RSHIFT: if (!ext) bits.rshift <= !brk;
        SC_CTRL: begin
          if (ext) bits.rctrl <= !brk;
          else     bits.lctrl <= !brk;
        end
        SC_ALT: begin
          if (ext) bits.ralt <= !brk;
          else     bits.lalt <= !brk;
        end
        default: ;
      endcase
    end
  end

  assign mods = {bits.lalt | bits.ralt, bits.lctrl | bits.rctrl, bits.lshift | bits.rshift};

endmodule

// File: rtl/ps2_scan_ctrl.sv
// Pops PS/2 scan bytes from the keyboard FIFO and turns them into key events plus modifier state.
// Latency: byte at FIFO head in cycle t -> ev_valid at t+3 at the earliest (IDLE, POP, DECODE).
// Backpressure: no byte is popped while an event is pending; bytes wait in the keyboard FIFO.
module ps2_scan_ctrl
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  input  logic       kb_overflow,
  output logic       kb_rdn,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [2:0] mods,
  output logic       ovf_flag,
  input  logic       ovf_clr
);

  state_t     state, state_nxt;
  logic [7:0] byte_q;
  logic       ext_pend, brk_pend;
  logic [2:0] skip_cnt;

  logic       emit, emit_ext, emit_brk;
  logic       set_ext, set_brk, clr_pend, load_skip, dec_skip;
  mod_bits_t  unused_mod_bits;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (kb_ready && !ev_valid) state_nxt = ST_POP;
      ST_POP:    state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign kb_rdn = (state != ST_POP);

  always_comb begin
    emit      = 1'b0;
    emit_ext  = 1'b0;
    emit_brk  = 1'b0;
    set_ext   = 1'b0;
    set_brk   = 1'b0;
    clr_pend  = 1'b0;
    load_skip = 1'b0;
    dec_skip  = 1'b0;
    if (state == ST_DECODE) begin
      if (skip_cnt != 3'd0) begin
        dec_skip = 1'b1;
      end else if (byte_q == SC_E0) begin
        set_ext = 1'b1;
      end else if (byte_q == SC_F0) begin
        set_brk = 1'b1;
      end else if (is_discard(byte_q)) begin
        clr_pend = 1'b1;
      end else if (byte_q == SC_E1) begin
        // Pause: report once as a plain make, swallow the rest of the sequence
        load_skip = 1'b1;
        emit      = 1'b1;
        clr_pend  = 1'b1;
      end else begin
        emit      = 1'b1;
        emit_ext  = ext_pend;
        emit_brk  = brk_pend;
        clr_pend  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_q   <= 8'h00;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
      skip_cnt <= 3'd0;
    end else begin
      if (state == ST_POP) byte_q <= kb_data;
      if (clr_pend) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else begin
        if (set_ext) ext_pend <= 1'b1;
        if (set_brk) brk_pend <= 1'b1;
      end
      if (load_skip)     skip_cnt <= SKIP_LEN;
      else if (dec_skip) skip_cnt <= skip_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid <= 1'b0;
      ev_code  <= 8'h00;
      ev_ext   <= 1'b0;
      ev_break <= 1'b0;
    end else if (emit) begin
      ev_valid <= 1'b1;
      ev_code  <= byte_q;
      ev_ext   <= emit_ext;
      ev_break <= emit_brk;
    end else if (ev_valid && ev_ready) begin
      ev_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)              ovf_flag <= 1'b0;
    else if (kb_overflow) ovf_flag <= 1'b1;
    else if (ovf_clr)     ovf_flag <= 1'b0;
  end

  // Per-side bits stay inside the block; only the merged mods leave it
  ps2_mod_tracker u_mods (
    .clk  (clk),
    .rst  (rst),
    .upd  (emit),
    .code (byte_q),
    .ext  (emit_ext),
    .brk  (emit_brk),
    .bits (unused_mod_bits),
    .mods (mods)
  );

endmodule

// File: doc/ps2_scan_ctrl.md
PS2_SCAN_CTRL -- requirements
Module: ps2_scan_ctrl

Interface
REQ-001 clk  in  1  system clock, 50 MHz; all state on posedge clk.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 kb_data  in  8  scan-code byte at the head of the keyboard FIFO; valid while kb_ready=1.
REQ-004 kb_ready  in  1  keyboard FIFO not empty.
REQ-005 kb_overflow  in  1  keyboard FIFO overflow flag.
REQ-006 kb_rdn  out  1  FIFO pop strobe, active-low; each low cycle consumes one byte.
REQ-007 ev_valid  out  1  key event held on ev_* outputs.
REQ-008 ev_ready  in  1  consumer accepts the event when ev_valid=1 and ev_ready=1.
REQ-009 ev_code  out  8  base scan code of the event.
REQ-010 ev_ext  out  1  event carried an 0xE0 prefix.
REQ-011 ev_break  out  1  key release (1) or key press (0).
REQ-012 mods  out  3  {alt, ctrl, shift} currently held, OR of left and right keys.
REQ-013 ovf_flag  out  1  sticky: keyboard overflow seen.
REQ-014 ovf_clr  in  1  clears ovf_flag.

Function
REQ-015 The FSM SHALL have three states: IDLE, POP, DECODE; kb_rdn=0 only in POP.
REQ-016 IDLE->POP SHALL occur when kb_ready=1 and ev_valid=0; otherwise the FSM stays in IDLE.
REQ-017 POP SHALL latch kb_data into a byte register and go to DECODE unconditionally; exactly one byte is popped per POP cycle.
REQ-018 DECODE SHALL go to IDLE, so a byte present at cycle t gives ev_valid=1 at t+3 at the earliest.
REQ-019 In DECODE, 0xE0 SHALL set ext_pend and 0xF0 SHALL set brk_pend; no event is emitted.
REQ-020 In DECODE, bytes 0x00, 0xFF, 0xAA, 0xFA, 0xEE and 0xFE SHALL be discarded and SHALL clear both pending flags.
REQ-021 In DECODE, 0xE1 SHALL load skip_cnt=7, emit an event with code 0xE1, ext=0 and break=0, and clear both pending flags.
REQ-022 While skip_cnt>0, each popped byte SHALL be discarded and SHALL decrement skip_cnt; it is not decoded and emits no event.
REQ-023 In DECODE, any other byte SHALL emit an event with code=byte, ext=ext_pend and break=brk_pend, then clear both pending flags.
REQ-024 An emitted event SHALL set ev_valid=1 and hold ev_code, ev_ext and ev_break stable until the cycle of acceptance; ev_valid clears on the next edge.
REQ-025 No POP SHALL start while ev_valid=1 (back-pressure); bytes wait in the keyboard FIFO.
REQ-026 Modifier tracking SHALL update in the emitting DECODE cycle: lshift 0x12, rshift 0x59, lctrl 0x14 with ext=0, rctrl 0x14 with ext=1, lalt 0x11 with ext=0, ralt 0x11 with ext=1; each bit is set on make and cleared on break.
REQ-027 A make/break sequence for 0x12 or 0x59 with ext=1 (fake shift) SHALL NOT change the shift bits, and the event is still emitted.
REQ-028 ovf_flag SHALL be set on any cycle with kb_overflow=1 and cleared by ovf_clr=1; if both occur in the same cycle, set wins.
REQ-029 A prefix followed only by a discarded byte SHALL leave no residue; the next code byte decodes clean.

Reset
REQ-030 On rst=1 at a clock edge, the block SHALL set state=IDLE, kb_rdn=1, ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, mods=0, all six modifier bits=0, ext_pend=0, brk_pend=0, skip_cnt=0 and ovf_flag=0.
REQ-031 Reset SHALL take precedence over all other inputs.
REQ-032 Reset in POP SHALL drive kb_rdn=1 from the next cycle on.
REQ-033 Any byte popped before reset SHALL be lost; no event is emitted for it.

Structure
REQ-034 A shared package ps2_pkg SHALL hold the state encoding and the scan-code constants (E0, F0, E1, the discard set, the modifier codes) and the skip length 7.
REQ-035 Modifier bit logic SHALL be one sub-module, ps2_mod_tracker, taking code, ext, break and an update strobe and producing the six bits and mods.
REQ-036 kb_rdn SHALL be decoded from the state register only, with no combinational path from kb_ready or kb_data.

Verification
REQ-037 Scenario: FIFO holds 0x1C -> exactly one kb_rdn pulse; ev_valid=1 three cycles later with code 0x1C, ext=0, break=0.
REQ-038 Scenario: E0 F0 75 with ev_ready=1 -> one event with code 0x75, ext=1, break=1; three pops total.
REQ-039 Scenario: 12, then 1C, then F0 12 -> mods=001 after the first event, both events emitted, then mods=000.
REQ-040 Scenario: E1 14 77 E1 F0 14 F0 77 -> a single event with code 0xE1 and break=0; the following 0x1C decodes normally.
REQ-041 Scenario: ev_ready=0 for 20 cycles with 3 bytes queued -> no pop during the stall; ev_* held stable; the remaining events follow in order once ev_ready=1.
REQ-042 Scenario: rst asserted during POP following an E0 byte, then FIFO holds 0x75 -> event code 0x75 with ext=0; kb_overflow pulse with ovf_clr held high -> ovf_flag=1.
